// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice that sits in front of the byte FIFO.
// Holds the receiver state encoding, frame constants and the baud-rate helpers.
// Optional feature macro used by the receiver: UART_RX_PARITY_EN (8E1 framing).
package uart_pkg;

    // Receiver states; PARITY is only reachable when the parity feature is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        WRITE  = 3'd5
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic STOP_LVL  = 1'b1;

    // Clocks per bit, truncating division. Callers keep the result >= 4 so that the
    // mid-bit strobe stays clear of the counter wrap.
    function automatic int calc_bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Width of a counter that holds 0..bps_cnt-1.
    function automatic int calc_cnt_w(input int bps_cnt);
        return (bps_cnt <= 2) ? 1 : $clog2(bps_cnt);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_wr_if.sv
// FIFO write-port bundle between the UART receiver and the byte FIFO.
//
// Handshake: wr_en is a single-cycle push strobe and wr_data is valid only while
// wr_en=1. full plays the role of an inverted ready: the receiver examines it in the
// cycle it wants to push and never raises wr_en while full=1, so every wr_en=1 cycle
// is exactly one accepted byte. There is no back-pressure stall; a refused byte is
// dropped by the receiver and reported separately.
interface uart_rx_fifo_wr_if;

    logic       full;
    logic       wr_en;
    logic [7:0] wr_data;

    // Receiver side: produces the strobe and the byte, observes the full flag.
    modport master (
        output wr_en,
        output wr_data,
        input  full
    );

    // FIFO side: consumes the strobe and the byte, reports full.
    modport slave (
        input  wr_en,
        input  wr_data,
        output full
    );

endinterface

// File: rtl/uart_rx_bps.sv
// Baud counter for the UART receiver: counts clocks within one bit period and raises
// a one-cycle sample strobe in the middle of each bit. Held at zero while disabled or
// cleared, so the first strobe after enabling lands half a bit after the start edge.
module uart_rx_bps
    import uart_pkg::*;
#(
    parameter int BPS_CNT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    output logic sample
);

    localparam int               CNT_W   = calc_cnt_w(BPS_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;

    // Free-running bit-period counter, 0..BPS_CNT-1, active only while enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign sample = enable && !clear && (cnt == CNT_MID);

endmodule

// File: rtl/uart_rx_fifo_wr.sv
// UART receiver feeding a byte FIFO write port.
// Samples rs_rx (8N1, LSB first) at mid-bit, pushes each good byte with a one-cycle
// wr_en strobe and reports framing / overrun faults as one-cycle pulses.
// Build option: define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err pulse.
// state_dbg mirrors the FSM state for observation.
module uart_rx_fifo_wr
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rs_rx,
    uart_rx_fifo_wr_if.master        fifo,
    output logic                     rx_busy,
    output logic                     frame_err,
    output logic                     overrun,
`ifdef UART_RX_PARITY_EN
    output logic                     parity_err,
`endif
    output rx_state_t                state_dbg
);

    // Clocks per bit; the configuration must keep this at 4 or more.
    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, BAUD);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t  state;
    rx_state_t  state_nxt;

    logic       rx_meta;
    logic       rx_s;
    logic       rx_d;
    logic       rx_fall;

    logic       sample;
    logic       bps_en;
    logic       bps_clr;

    logic [7:0] shift_q;
    logic [2:0] bit_idx;
    logic [7:0] wr_data_q;
    logic       push;
`ifdef UART_RX_PARITY_EN
    logic       parity_bad_q;
`endif

    // Two-flop synchroniser for the asynchronous line plus one more flop for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rs_rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign rx_fall = rx_d && !rx_s;

    // The bit clock runs only while a frame is in progress and restarts from zero on
    // every start edge.
    assign bps_en  = (state != IDLE);
    assign bps_clr = (state == IDLE);

    uart_rx_bps #(
        .BPS_CNT (BPS_CNT)
    ) u_bps (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (bps_en),
        .clear  (bps_clr),
        .sample (sample)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and the one-cycle output pulses. Pulses come straight from the state
    // so that they drop together with an asynchronous reset.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        frame_err = 1'b0;
        overrun   = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (sample) begin
                    state_nxt = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample && (bit_idx == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                // Returning to IDLE here (mid-stop) leaves half a bit to catch the next
                // start edge of a back-to-back frame.
                if (sample) begin
                    if (rx_s == STOP_LVL) begin
                        state_nxt = WRITE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                if (parity_bad_q) begin
                    parity_err = 1'b1;
                end else
`endif
                if (fifo.full) begin
                    overrun = 1'b1;
                end else begin
                    push = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Data path: shift in LSB first (new bit enters at bit 7) and count data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bit_idx <= '0;
        end else if (state == IDLE) begin
            bit_idx <= '0;
        end else if ((state == DATA) && sample) begin
            shift_q <= {rx_s, shift_q[7:1]};
            bit_idx <= bit_idx + 3'd1;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: data bits XOR parity bit must be zero for a good byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_bad_q <= 1'b0;
        end else if ((state == PARITY) && sample) begin
            parity_bad_q <= (^shift_q) ^ rx_s;
        end
    end
`endif

    // Remember the last pushed byte so wr_data stays stable between writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data_q <= '0;
        end else if (push) begin
            wr_data_q <= shift_q;
        end
    end

    assign fifo.wr_en   = push;
    assign fifo.wr_data = push ? shift_q : wr_data_q;
    assign rx_busy      = (state != IDLE);
    assign state_dbg    = state;

endmodule

// File: tb/tb_uart_rx_fifo_wr.sv
// Self-checking bench for uart_rx_fifo_wr at BPS_CNT=10.
// A line driver serialises frames; each frame also pushes the one event it must cause
// (write/frame_err/overrun/parity_err) with the window in which it must appear. A single
// compare process checks every pulse against that queue and wr_data hold every cycle.
`timescale 1ns/1ps
module tb_uart_rx_fifo_wr;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int STOP_IDX = FRAME_BITS - 1;

    localparam logic [1:0] EV_WRITE = 2'd0;
    localparam logic [1:0] EV_FERR  = 2'd1;
    localparam logic [1:0] EV_OVR   = 2'd2;
    localparam logic [1:0] EV_PERR  = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  data;
        logic [31:0] t0;
    } exp_t;

    logic [$bits(exp_t)-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    logic rs_rx;
    logic rx_busy;
    logic frame_err;
    logic overrun;
    logic pe_obs;
    rx_state_t state_dbg;
`ifdef UART_RX_PARITY_EN
    logic parity_err;
    assign pe_obs = parity_err;
`else
    assign pe_obs = 1'b0;
`endif

    uart_rx_fifo_wr_if fifo_if();

    uart_rx_fifo_wr #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rs_rx     (rs_rx),
        .fifo      (fifo_if),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- counters and model state ----------------
    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] model_last_wr = 8'h00;
    int         seen_wr = 0;
    int         seen_fe = 0;
    int         seen_ov = 0;
    int         seen_pe = 0;
    logic [7:0] seen_data_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard compare ----------------
    exp_t       e_cur;
    int         npulse;
    logic [1:0] obs_kind;
    int         win_lo;
    int         win_hi;

    always @(negedge clk) begin
        if (rst_n) begin
            npulse = int'(fifo_if.wr_en) + int'(frame_err) + int'(overrun) + int'(pe_obs);
            if (npulse != 0) begin
                check("single_pulse", npulse, 1);
                obs_kind = fifo_if.wr_en ? EV_WRITE : frame_err ? EV_FERR : overrun ? EV_OVR : EV_PERR;
                if (fifo_if.wr_en) begin
                    seen_wr++;
                    seen_data_q.push_back(fifo_if.wr_data);
                end
                if (frame_err) seen_fe++;
                if (overrun)   seen_ov++;
                if (pe_obs)    seen_pe++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, obs_kind}, 32'hFFFF);
                end else begin
                    e_cur  = exp_q.pop_front();
                    win_lo = int'(e_cur.t0) + STOP_IDX * B + 2;
                    win_hi = int'(e_cur.t0) + (STOP_IDX + 1) * B;
                    check("event_kind", {30'd0, obs_kind}, {30'd0, e_cur.kind});
                    check("event_not_early", (cyc >= win_lo) ? 1 : 0, 1);
                    check("event_not_late", (cyc <= win_hi) ? 1 : 0, 1);
                    if (e_cur.kind == EV_WRITE) begin
                        check("wr_data", fifo_if.wr_data, e_cur.data);
                        model_last_wr = e_cur.data;
                    end
                end
            end else begin
                check("wr_data_hold", fifo_if.wr_data, model_last_wr);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_bit(input logic v);
        rs_rx = v;
        repeat (B) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge that ends the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                              input logic f);
        exp_t e;
        fifo_if.full = f;
        e.data = d;
        e.t0   = cyc;
        if (!stop)        e.kind = EV_FERR;
`ifdef UART_RX_PARITY_EN
        else if (par_bad) e.kind = EV_PERR;
`endif
        else if (f)       e.kind = EV_OVR;
        else              e.kind = EV_WRITE;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_bad);
`else
        if (par_bad) rs_rx = 1'b1;
`endif
        drive_bit(stop);
        if (!stop) begin
            rs_rx = 1'b1;
            repeat (B) @(negedge clk);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * FRAME_BITS * B && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rs_rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    endtask

    // ---------------- stimulus ----------------
    int b_wr, b_fe, b_ov, b_pe;
    logic [7:0] part_byte;

    task automatic snap();
        b_wr = seen_wr; b_fe = seen_fe; b_ov = seen_ov; b_pe = seen_pe;
    endtask

    initial begin
        rst_n = 1'b0;
        rs_rx = 1'b1;
        fifo_if.full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_en", fifo_if.wr_en, 0);
        check("rst_wr_data", fifo_if.wr_data, 8'h00);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        idle(5);

        // 1: plain frame
        snap();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drain();
        check("t1_wr_count", seen_wr - b_wr, 1);
        check("t1_data", seen_data_q[$], 8'hA5);
        check("t1_fe_count", seen_fe - b_fe, 0);
        check("t1_ov_count", seen_ov - b_ov, 0);

        // 2: false start
        snap();
        rs_rx = 1'b0;
        repeat (3) @(negedge clk);
        rs_rx = 1'b1;
        check("t2_busy_seen", rx_busy, 1);
        repeat (6) @(negedge clk);
        check("t2_busy_cleared", rx_busy, 0);
        idle(2 * B);
        check("t2_wr_count", seen_wr - b_wr, 0);

        // 3: bad stop bit
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        drain();
        check("t3_fe_count", seen_fe - b_fe, 1);
        check("t3_wr_count", seen_wr - b_wr, 0);
        check("t3_busy_after", rx_busy, 0);

        // 4: overrun, then recovery
        snap();
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        drain();
        check("t4_ov_count", seen_ov - b_ov, 1);
        check("t4_wr_count", seen_wr - b_wr, 1);
        check("t4_data", seen_data_q[$], 8'h0F);

        // 5: back-to-back frames
        snap();
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        drain();
        check("t5_wr_count", seen_wr - b_wr, 2);
        check("t5_first", seen_data_q[seen_data_q.size() - 2], 8'h00);
        check("t5_second", seen_data_q[$], 8'hFF);

        // 6: reset in the middle of data bit 4
        part_byte = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(part_byte[i]);
        rs_rx = part_byte[4];
        repeat (B / 2) @(negedge clk);
        check("t6_busy_before", rx_busy, 1);
        #1;
        rst_n = 1'b0;
        model_last_wr = 8'h00;
        #1;
        check("t6_wr_en", fifo_if.wr_en, 0);
        check("t6_wr_data", fifo_if.wr_data, 8'h00);
        check("t6_busy", rx_busy, 0);
        check("t6_frame_err", frame_err, 0);
        check("t6_overrun", overrun, 0);
        rs_rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2 * B);
        snap();
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        drain();
        check("t6_wr_count", seen_wr - b_wr, 1);
        check("t6_data", seen_data_q[$], 8'h81);

`ifdef UART_RX_PARITY_EN
        // 7: parity error then good parity
        snap();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        drain();
        check("t7_pe_count", seen_pe - b_pe, 1);
        check("t7_wr_none", seen_wr - b_wr, 0);
        check("t7_ov_none", seen_ov - b_ov, 0);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        drain();
        check("t7_wr_count", seen_wr - b_wr, 1);
        check("t7_data", seen_data_q[$], 8'hA5);
`endif

        // randomized frames with random gaps, faults and full
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       stop;
            logic       pb;
            logic       f;
            int         gap;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            f    = ($urandom_range(0, 3) == 0);
`ifdef UART_RX_PARITY_EN
            pb   = ($urandom_range(0, 3) == 0);
`else
            pb   = 1'b0;
`endif
            send_frame(d, stop, pb, f);
            gap = $urandom_range(0, 12);
            rs_rx = 1'b1;
            for (int g = 0; g < gap; g++) begin
                fifo_if.full = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 9) == 0) begin
                drain();
                rs_rx = 1'b0;
                repeat (3) @(negedge clk);
                idle(2 * B);
            end
        end
        drain();
        check("final_busy", rx_busy, 0);

        summary();
        $finish;
    end

    // Watchdog: ends the run if the stimulus ever stalls.
    initial begin
        #800_000;
        miscompares++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

endmodule
